psa_accum_seq: RTL and testbench

Sequencer that accumulates a burst of 16-bit packed words lane-wise (four independent signed 4-bit lanes) with per-lane saturation. It sits beside the execute-stage parallel-sub-word adder path. It accepts a start command with a burst length and consumes operand words over a valid/ready handshake. It reports the saturated packed sum, plus sticky per-lane saturation flags, with a one-cycle done pulse.

---
 rtl/psa_accum_seq_pkg.sv | 18 +
 rtl/psa_accum_seq_lane_sat.sv | 29 ++
 rtl/psa_accum_seq.sv | 109 ++++++++++
 tb/tb_psa_accum_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/psa_accum_seq_pkg.sv
// Shared types and constants for the packed sub-word accumulate sequencer.
// Four independent signed 4-bit lanes packed into one 16-bit word.
package psa_accum_seq_pkg;

    localparam int LANE_W    = 4;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;

    localparam logic [LANE_W-1:0] SAT_POS = 4'h7;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'h8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/psa_accum_seq_lane_sat.sv
// One signed 4-bit lane: wrap-around add clamped to the lane range, with overflow flag.
module psa_lane_sat
    import psa_accum_seq_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum,
    output logic              sat
);

    logic [LANE_W-1:0] raw_sum;
    logic              pos_ovf;
    logic              neg_ovf;

    // Overflow only when both operands share a sign that the wrapped sum lost.
    always_comb begin
        raw_sum = a + b;
        pos_ovf = ~a[LANE_W-1] & ~b[LANE_W-1] &  raw_sum[LANE_W-1];
        neg_ovf =  a[LANE_W-1] &  b[LANE_W-1] & ~raw_sum[LANE_W-1];
        sum     = raw_sum;
        if (pos_ovf) begin
            sum = SAT_POS;
        end else if (neg_ovf) begin
            sum = SAT_NEG;
        end
        sat = pos_ovf | neg_ovf;
    end

endmodule

// File: rtl/psa_accum_seq.sv
// Burst sequencer: accepts len packed words over valid/ready and accumulates them
// lane-wise with saturation, then pulses done with the final sum and sticky flags.
module psa_accum_seq
    import psa_accum_seq_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [COUNT_W-1:0]   len,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    result,
    output logic [NUM_LANES-1:0] sat_flags
);

    state_t                 state_q, state_d;
    logic [COUNT_W-1:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]      acc_q, acc_d;
    logic [NUM_LANES-1:0]   flags_q, flags_d;
    logic                   busy_q, busy_d;
    logic                   in_ready_q, in_ready_d;
    logic                   done_q, done_d;

    logic [DATA_W-1:0]      lane_sum;
    logic [NUM_LANES-1:0]   lane_sat;
    logic                   beat;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            psa_lane_sat u_lane (
                .a   (acc_q[gi*LANE_W +: LANE_W]),
                .b   (in_data[gi*LANE_W +: LANE_W]),
                .sum (lane_sum[gi*LANE_W +: LANE_W]),
                .sat (lane_sat[gi])
            );
        end
    endgenerate

    assign beat = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    flags_d = '0;
                    if (len != '0) begin
                        remaining_d = len;
                        state_d     = ACCUM;
                    end else begin
                        state_d     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d       = lane_sum;
                    flags_d     = flags_q | lane_sat;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == COUNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are decoded from the next state so they register with it.
        busy_d     = (state_d != IDLE);
        in_ready_d = (state_d == ACCUM);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = acc_q;
    assign sat_flags = flags_q;

endmodule

// File: tb/tb_psa_accum_seq.sv
// Scoreboard bench: each burst pushes its modelled result; the done monitor pops and checks.
module tb_psa_accum_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  sat_flags;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
        int          beats;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          start_cyc = 0;
    int          beat_cnt  = 0;
    logic [15:0] wbuf [16];

    psa_accum_seq #(.COUNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .sat_flags (sat_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer add per lane, clamped to [-8, 7].
    task automatic model(input int n, output logic [15:0] res, output logic [3:0] flg);
        int a, b, s;
        res = 16'h0;
        flg = 4'h0;
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 4; l++) begin
                a = int'(res[l*4 +: 4]);
                b = int'(wbuf[i][l*4 +: 4]);
                if (a > 7) a = a - 16;
                if (b > 7) b = b - 16;
                s = a + b;
                if (s > 7) begin
                    s = 7;
                    flg[l] = 1'b1;
                end else if (s < -8) begin
                    s = -8;
                    flg[l] = 1'b1;
                end
                res[l*4 +: 4] = 4'(s);
            end
        end
    endtask

    // Done monitor: counts accepted beats and checks each completed burst.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            beat_cnt = 0;
        end else begin
            if (in_valid && in_ready) beat_cnt++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] burst done: result=%04h flags=%04b beats=%0d lat=%0d",
                             result, sat_flags, beat_cnt, cyc - start_cyc);
                    chk("result", 32'(result), 32'(e.res));
                    chk("sat_flags", 32'(sat_flags), 32'(e.flg));
                    chk("beats", 32'(beat_cnt), 32'(e.beats));
                    if (e.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                end
                beat_cnt = 0;
            end
        end
    end

    task automatic run_burst(input int n, input int gap, input bit mid_start, input bit chk_lat);
        exp_t e;
        bit   ok;
        bit   acc_now;
        model(n, e.res, e.flg);
        e.beats = n;
        e.lat   = chk_lat ? n + 1 : -1;
        @(posedge clk); #1;
        start     = 1'b1;
        len       = 4'(n);
        start_cyc = cyc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'hF;
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                @(posedge clk); #1;
            end
            if (mid_start && i == 1) start = 1'b1;
            in_valid = 1'b1;
            in_data  = wbuf[i];
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                acc_now = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                if (acc_now) begin
                    ok = 1'b1;
                    break;
                end
            end
            in_valid = 1'b0;
            in_data  = 16'hDEAD;
            if (!ok) chk("beat_timeout", 32'd0, 32'd1);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_after_burst", 32'(busy), 32'd0);
    endtask

    task automatic set_words(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        wbuf[0] = w0;
        wbuf[1] = w1;
        wbuf[2] = w2;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 4'h0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(sat_flags), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-burst: one of three beats accepted, then reset for two cycles.
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'd3;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_result", 32'(result), 32'h1111);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_flags", 32'(sat_flags), 32'd0);

        set_words(16'h1111, 16'h2222, 16'h1111);
        run_burst(3, 0, 1'b0, 1'b1);
        chk("plain_hold", 32'(result), 32'h4444);
        set_words(16'h5555, 16'h3333, 16'h0);
        run_burst(2, 0, 1'b0, 1'b1);
        set_words(16'h0F70, 16'h0F10, 16'h0);
        run_burst(2, 0, 1'b0, 1'b1);
        set_words(16'h8888, 16'hFFFF, 16'h0);
        run_burst(2, 0, 1'b0, 1'b1);
        chk("neg_hold", 32'(result), 32'h8888);
        run_burst(0, 0, 1'b0, 1'b1);
        set_words(16'h1234, 16'h2143, 16'h0);
        run_burst(2, 3, 1'b0, 1'b0);
        set_words(16'h7777, 16'h1111, 16'h0);
        run_burst(2, 2, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(1, 15));
            for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
            run_burst(n, 0, 1'b0, 1'b1);
        end

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
